m_btb_pred: RTL
===============

# m_btb_pred

Parametrised branch-target buffer and direction predictor for the 5-stage pipeline. Fetch looks it up combinationally with the current PC to pick the next PC. Resolved conditional branches train it from EX. It generalises the 4-slot predictor with:
- configurable entry count, address width and counter width;
- explicit valid bits and a true-LRU allocator;
- asynchronous reset and a flush input;
- optional same-cycle update-to-lookup bypass.

## Interface
- ADDR_W, 11, width of instruction word addresses (PC and target)
- ENTRIES, 4, number of fully associative entries (power of two, 2..32)
- CNT_W, 2, width of each saturating direction counter (2..4)
- w_clk  input  1  clock, all state updates on rising edge
- w_rst  input  1  reset, asynchronous, active-high
- w_inv  input  1  invalidate all entries (synchronous)
- w_ue  input  1  update enable: a resolved conditional branch is in EX
- w_uaddr  input  ADDR_W  PC of the resolved branch
- w_utaken  input  1  resolved direction, 1 = taken
- w_udst  input  ADDR_W  resolved target address
- w_laddr  input  ADDR_W  fetch PC to look up
- w_lhit  output  1  lookup hit on a valid entry
- w_ltaken  output  1  predicted taken (counter MSB); 0 on miss
- w_ldst  output  ADDR_W  predicted target; 0 on miss

## Operation
- Per-entry state: valid, tag (ADDR_W), dst (ADDR_W), cnt (CNT_W), age (clog2(ENTRIES)).
- Lookup (combinational):
  - hit = valid && tag == w_laddr; lowest index wins if several match.
  - On miss, w_ltaken and w_ldst are forced to 0.
  - Lookups never change state or LRU.
- Update on a hit (w_ue=1, valid match on w_uaddr):
  - cnt saturates: +1 if taken, −1 if not; stays at 2^CNT_W−1 and 0 at the ends.
  - If w_utaken, dst <= w_udst.
  - Entry is touched.
- Update on a miss (allocate):
  - Victim is the lowest-index invalid entry; if all are valid, the entry with age ENTRIES−1.
  - Victim gets valid=1, tag=w_uaddr, dst=w_udst.
  - cnt = 2^(CNT_W−1) (weak taken) if w_utaken, else 2^(CNT_W−1)−1 (weak not-taken).
  - Entry is touched.
- Touch of an entry with age a:
  - That entry's age becomes 0.
  - Every other entry with age < a increments by 1.
  - Ages therefore always remain a permutation of 0..ENTRIES−1.
- w_inv: all valid bits cleared, age[i]=i. Takes priority over w_ue in the same cycle; that update is dropped.
- Reset: valid=0, tag=0, dst=0, cnt=0, age[i]=i. Outputs are therefore 0 (w_lhit=0, w_ltaken=0, w_ldst=0) for any w_laddr while reset is high and afterwards until the first update.

## Timing
- Lookup has zero latency: outputs follow w_laddr/state combinationally within the cycle.
- Update latency is one cycle: an update sampled at edge N is visible to lookups after edge N.
- Reset asserted mid-cycle clears state immediately, without waiting for an edge; deassertion is synchronised by the parent.
- Same-cycle update and lookup of the same address:
  - without bypass, the lookup sees the pre-update state;
  - with bypass, see Configuration.
- Back-to-back updates of the same address each apply, with no lost increments.

## Configuration
- BTB_BYPASS_EN defined:
  - When w_ue=1, w_inv=0 and w_uaddr==w_laddr in the same cycle, outputs reflect the post-edge state: w_lhit=1, w_ltaken=MSB of the new cnt, w_ldst=new dst.
  - When w_inv=1, w_lhit=0 that cycle.
- BTB_BYPASS_EN undefined: outputs depend on registered state only.

## Structure
- Shared package btb_pkg:
  - functions for the saturating increment/decrement and the initial counter values (weak taken / weak not-taken);
  - localparam for the age width, clog2(ENTRIES).
- One sub-module, m_satcnt: CNT_W saturating counter with load, inc and dec. It is instantiated per entry through a generate loop.
- Tag compare, victim select and LRU ageing stay in m_btb_pred.

## Test plan
- Reset, then look up 0x010 -> w_lhit=0, w_ltaken=0, w_ldst=0. Assert w_rst mid-run after training -> all lookups miss immediately.
- Update 0x010 taken, dst 0x020 (CNT_W=2) -> next cycle lookup 0x010 gives hit=1, taken=1, dst=0x020, cnt=2. Two not-taken updates -> cnt=0, taken=0. A third not-taken update -> cnt stays 0.
- ENTRIES=4: allocate 0x1,0x2,0x3,0x4, then hit 0x1, then allocate 0x5 -> 0x2 is evicted, and 0x1, 0x3, 0x4, 0x5 all hit.
- w_inv together with w_ue for new address 0x7 -> next cycle every lookup misses, including 0x7, and age[i]=i.
- Same-cycle update and lookup of 0x010 on a miss, taken, dst 0x030 -> with BTB_BYPASS_EN: hit=1, taken=1, dst=0x030 that cycle. Without it: hit=0 that cycle and hit=1 the next.
- Random update/lookup stream (ENTRIES=8, CNT_W=3) checked against a reference model every cycle. Also check each cycle that ages remain a permutation of 0..7.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types and helpers for the branch-target buffer and its counters.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package btb_pkg;

    // Widest direction counter any instance may use; helpers work at this width.
    localparam int CNT_MAX_W = 4;
    typedef logic [CNT_MAX_W-1:0] cnt_max_t;

    // Age width for the default 4-entry configuration; instances derive theirs
    // from btb_age_w(ENTRIES).
    localparam int BTB_ENTRIES_DEF = 4;
    localparam int BTB_AGE_W       = $clog2(BTB_ENTRIES_DEF);

    function automatic int btb_age_w(input int entries);
        return $clog2(entries);
    endfunction

    // Saturating +1 for a w-bit counter held in the low bits of c.
    function automatic cnt_max_t cnt_sat_inc(input cnt_max_t c, input int w);
        cnt_max_t top;
        top = cnt_max_t'((1 << w) - 1);
        return (c >= top) ? c : c + cnt_max_t'(1);
    endfunction

    // Saturating -1; floors at zero.
    function automatic cnt_max_t cnt_sat_dec(input cnt_max_t c);
        return (c == '0) ? c : c - cnt_max_t'(1);
    endfunction

    // Weakly-taken start value: MSB set, all lower bits clear.
    function automatic cnt_max_t cnt_weak_t(input int w);
        return cnt_max_t'(1 << (w - 1));
    endfunction

    // Weakly-not-taken start value: one below weakly-taken.
    function automatic cnt_max_t cnt_weak_nt(input int w);
        return cnt_max_t'((1 << (w - 1)) - 1);
    endfunction

endpackage

// File: rtl/m_satcnt.sv
// Saturating direction counter (CNT_W bits) with load, increment and decrement.
// Latency: one cycle from load/inc/dec to cnt; taken_nxt_o shows the post-edge MSB now.
// Backpressure: none, every request is applied on the next rising edge.
// Ports: clk_i/rst_i clock and async active-high reset; load_i/load_val_i
// overwrite; inc_i/dec_i step (load wins); taken_o current MSB; taken_nxt_o next MSB.
module m_satcnt
    import btb_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic             taken_o,
    output logic             taken_nxt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = CNT_W'(cnt_sat_inc(cnt_max_t'(cnt_q), CNT_W));
        end else if (dec_i) begin
            cnt_d = CNT_W'(cnt_sat_dec(cnt_max_t'(cnt_q)));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign taken_o     = cnt_q[CNT_W-1];
    assign taken_nxt_o = cnt_d[CNT_W-1];

endmodule

// File: rtl/m_btb_pred.sv
// Fully associative BTB + direction predictor with true-LRU allocation; fetch looks up, EX trains.
// Latency: lookup is combinational (0 cycles); an update is visible after the next rising edge.
// Backpressure: none, one update per cycle is always accepted; w_inv drops a same-cycle update.
// Ports: w_clk/w_rst clock and async active-high reset; w_inv clears all entries;
// w_ue/w_uaddr/w_utaken/w_udst training from EX; w_laddr fetch PC -> w_lhit/w_ltaken/w_ldst.
// Optional build macro BTB_BYPASS_EN: a same-cycle update of the looked-up PC is
// forwarded to the lookup outputs (and w_inv forces a miss that cycle).
module m_btb_pred
    import btb_pkg::*;
#(
    parameter int ADDR_W  = 11,
    parameter int ENTRIES = 4,
    parameter int CNT_W   = 2
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_inv,
    input  logic              w_ue,
    input  logic [ADDR_W-1:0] w_uaddr,
    input  logic              w_utaken,
    input  logic [ADDR_W-1:0] w_udst,
    input  logic [ADDR_W-1:0] w_laddr,
    output logic              w_lhit,
    output logic              w_ltaken,
    output logic [ADDR_W-1:0] w_ldst
);

    localparam int               AGE_W      = btb_age_w(ENTRIES);
    localparam logic [AGE_W-1:0] AGE_OLDEST = AGE_W'(ENTRIES - 1);

    logic [ENTRIES-1:0]            vld_q, vld_d;
    logic [ADDR_W-1:0]             tag_q [ENTRIES];
    logic [ADDR_W-1:0]             tag_d [ENTRIES];
    logic [ADDR_W-1:0]             dst_q [ENTRIES];
    logic [ADDR_W-1:0]             dst_d [ENTRIES];
    logic [ENTRIES-1:0][AGE_W-1:0] age_q, age_d;
    logic [ENTRIES-1:0]            cnt_taken;
    logic [ENTRIES-1:0]            cnt_taken_nxt;

    logic             l_hit, u_hit, do_upd;
    logic [AGE_W-1:0] l_idx, u_idx, vic_idx, sel_idx;
    logic [CNT_W-1:0] init_cnt;

    // Scanning from the top index down lets the lowest matching index win.
    // The oldest entry is the fallback victim; any invalid entry overrides it.
    always_comb begin : match_scan
        l_hit   = 1'b0;
        l_idx   = '0;
        u_hit   = 1'b0;
        u_idx   = '0;
        vic_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (age_q[i] == AGE_OLDEST) begin
                vic_idx = AGE_W'(i);
            end
        end
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (vld_q[i] && tag_q[i] == w_laddr) begin
                l_hit = 1'b1;
                l_idx = AGE_W'(i);
            end
            if (vld_q[i] && tag_q[i] == w_uaddr) begin
                u_hit = 1'b1;
                u_idx = AGE_W'(i);
            end
            if (!vld_q[i]) begin
                vic_idx = AGE_W'(i);
            end
        end
    end

    assign do_upd   = w_ue && !w_inv;
    assign sel_idx  = u_hit ? u_idx : vic_idx;
    assign init_cnt = w_utaken ? CNT_W'(cnt_weak_t(CNT_W)) : CNT_W'(cnt_weak_nt(CNT_W));

    always_comb begin : next_state
        vld_d = vld_q;
        age_d = age_q;
        for (int i = 0; i < ENTRIES; i++) begin
            tag_d[i] = tag_q[i];
            dst_d[i] = dst_q[i];
        end
        if (w_inv) begin
            vld_d = '0;
            for (int i = 0; i < ENTRIES; i++) begin
                age_d[i] = AGE_W'(i);
            end
        end else if (w_ue) begin
            // Touch: selected entry becomes youngest, entries younger than it age by one.
            for (int i = 0; i < ENTRIES; i++) begin
                if (AGE_W'(i) == sel_idx) begin
                    age_d[i] = '0;
                end else if (age_q[i] < age_q[sel_idx]) begin
                    age_d[i] = age_q[i] + AGE_W'(1);
                end
            end
            if (!u_hit) begin
                vld_d[sel_idx] = 1'b1;
                tag_d[sel_idx] = w_uaddr;
                dst_d[sel_idx] = w_udst;
            end else if (w_utaken) begin
                dst_d[sel_idx] = w_udst;
            end
        end
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            vld_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                dst_q[i] <= '0;
                age_q[i] <= AGE_W'(i);
            end
        end else begin
            vld_q <= vld_d;
            age_q <= age_d;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= tag_d[i];
                dst_q[i] <= dst_d[i];
            end
        end
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_cnt
        logic sel_g;
        assign sel_g = do_upd && (sel_idx == AGE_W'(g));
        m_satcnt #(.CNT_W(CNT_W)) u_cnt (
            .clk_i       (w_clk),
            .rst_i       (w_rst),
            .load_i      (sel_g && !u_hit),
            .load_val_i  (init_cnt),
            .inc_i       (sel_g && u_hit && w_utaken),
            .dec_i       (sel_g && u_hit && !w_utaken),
            .taken_o     (cnt_taken[g]),
            .taken_nxt_o (cnt_taken_nxt[g])
        );
    end

    always_comb begin : lookup_out
        w_lhit   = l_hit;
        w_ltaken = l_hit && cnt_taken[l_idx];
        w_ldst   = l_hit ? dst_q[l_idx] : '0;
`ifdef BTB_BYPASS_EN
        // The selected entry's next-state values are exactly what a lookup
        // would see after the edge, so forward them directly.
        if (w_inv) begin
            w_lhit   = 1'b0;
            w_ltaken = 1'b0;
            w_ldst   = '0;
        end else if (w_ue && w_uaddr == w_laddr) begin
            w_lhit   = 1'b1;
            w_ltaken = cnt_taken_nxt[sel_idx];
            w_ldst   = dst_d[sel_idx];
        end
`endif
    end

`ifndef BTB_BYPASS_EN
    // Next-state counter MSBs only feed the forwarding path.
    logic taken_nxt_unused;
    assign taken_nxt_unused = ^cnt_taken_nxt;
`endif

endmodule
